// File: rtl/cont_updown_param.sv
// Multi-mode bounded counter: up-wrap, down-wrap, bounce or hold between run-time bounds lo..hi.
// Emits a one-cycle turn pulse whenever the count wraps or reverses direction.
module cont_updown_param #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] sa,
    output logic             dir,
    output logic             turn,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    mode_t            mode_q;
    logic [WIDTH-1:0] sa_nxt;
    logic             dir_nxt;
    logic             turn_nxt;
    logic             out_of_range;

    assign err          = (lo > hi);
    assign mode_q       = mode_t'(mode);
    assign out_of_range = (sa < lo) || (sa > hi);

    always_comb begin
        sa_nxt   = sa;
        dir_nxt  = dir;
        turn_nxt = 1'b0;
        if (load) begin
            sa_nxt = load_val;
        end else if (err || !en || mode_q == MODE_HOLD) begin
            sa_nxt = sa;
        end else if (out_of_range) begin
            // Re-enter the window at the end the current mode counts away from.
            if (mode_q == MODE_DOWN) begin
                sa_nxt  = hi;
                dir_nxt = 1'b1;
            end else begin
                sa_nxt  = lo;
                dir_nxt = 1'b0;
            end
        end else if (lo == hi) begin
            sa_nxt = lo;
        end else begin
            case (mode_q)
                MODE_UP: begin
                    dir_nxt = 1'b0;
                    if (sa == hi) begin
                        sa_nxt   = lo;
                        turn_nxt = 1'b1;
                    end else begin
                        sa_nxt = sa + 1'b1;
                    end
                end
                MODE_DOWN: begin
                    dir_nxt = 1'b1;
                    if (sa == lo) begin
                        sa_nxt   = hi;
                        turn_nxt = 1'b1;
                    end else begin
                        sa_nxt = sa - 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // Endpoints are shown once per sweep: step straight past them on reversal.
                    if (!dir) begin
                        if (sa == hi) begin
                            sa_nxt   = hi - 1'b1;
                            dir_nxt  = 1'b1;
                            turn_nxt = 1'b1;
                        end else begin
                            sa_nxt = sa + 1'b1;
                        end
                    end else begin
                        if (sa == lo) begin
                            sa_nxt   = lo + 1'b1;
                            dir_nxt  = 1'b0;
                            turn_nxt = 1'b1;
                        end else begin
                            sa_nxt = sa - 1'b1;
                        end
                    end
                end
                default: sa_nxt = sa;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sa   <= '0;
            dir  <= 1'b0;
            turn <= 1'b0;
        end else begin
            sa   <= sa_nxt;
            dir  <= dir_nxt;
            turn <= turn_nxt;
        end
    end

endmodule

// File: tb/tb_cont_updown_param.sv
// Directed-vector bench for cont_updown_param (WIDTH=4); expected values are hand-derived.
module tb_cont_updown_param;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] sa;
    logic       dir;
    logic       turn;
    logic       err;

    int passed = 0;
    int total  = 0;

    cont_updown_param #(.WIDTH(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .lo       (lo),
        .hi       (hi),
        .load     (load),
        .load_val (load_val),
        .sa       (sa),
        .dir      (dir),
        .turn     (turn),
        .err      (err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; mode = 2'b00; lo = 4'd0; hi = 4'd15;
        load = 1'b0; load_val = 4'd0;
        #2;
        total++;
        if ({sa, dir, turn} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_initial: got sa=%0d dir=%0b turn=%0b want 0/0/0", sa, dir, turn);
        else passed++;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_held: got sa=%0d dir=%0b turn=%0b want 0/0/0", sa, dir, turn);
        else passed++;
    endtask

    task automatic test_bounce();
        logic [3:0] esa;
        logic       edir;
        logic       eturn;
        mode = 2'b10; lo = 4'd0; hi = 4'd15; en = 1'b1;
        #2 reset = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            if (k <= 15)      begin esa = 4'(k);      edir = 1'b0; eturn = 1'b0; end
            else if (k == 16) begin esa = 4'd14;      edir = 1'b1; eturn = 1'b1; end
            else if (k <= 30) begin esa = 4'(30 - k); edir = 1'b1; eturn = 1'b0; end
            else              begin esa = 4'd1;       edir = 1'b0; eturn = 1'b1; end
            total++;
            if ({sa, dir, turn} !== {esa, edir, eturn})
                $display("FAIL bounce_step%0d: got sa=%0d dir=%0b turn=%0b want %0d/%0b/%0b",
                         k, sa, dir, turn, esa, edir, eturn);
            else passed++;
        end
    endtask

    task automatic test_upwrap();
        logic [3:0] exp_sa [5] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3};
        logic       exp_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b0; #2;
        mode = 2'b00; lo = 4'd3; hi = 4'd6; en = 1'b1;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({sa, dir, turn} !== {exp_sa[k], 1'b0, exp_t[k]})
                $display("FAIL upwrap_step%0d: got sa=%0d dir=%0b turn=%0b want %0d/0/%0b",
                         k, sa, dir, turn, exp_sa[k], exp_t[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_midturn();
        // turn is high here from the 6->3 wrap; drop reset mid-cycle
        #3 reset = 1'b0;
        #1;
        total++;
        if ({sa, dir, turn} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_midturn: got sa=%0d dir=%0b turn=%0b want 0/0/0", sa, dir, turn);
        else passed++;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL reset_hold_edge: got sa=%0d dir=%0b turn=%0b want 0/0/0", sa, dir, turn);
        else passed++;
        #2 reset = 1'b1;
    endtask

    task automatic test_downwrap();
        logic [3:0] exp_sa [6] = '{4'd9, 4'd5, 4'd4, 4'd3, 4'd2, 4'd5};
        logic       exp_d  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        mode = 2'b01; lo = 4'd2; hi = 4'd5; en = 1'b1;
        load = 1'b1; load_val = 4'd9;
        for (int k = 0; k < 6; k++) begin
            tick();
            load = 1'b0;
            total++;
            if ({sa, dir, turn} !== {exp_sa[k], exp_d[k], exp_t[k]})
                $display("FAIL downwrap_step%0d: got sa=%0d dir=%0b turn=%0b want %0d/%0b/%0b",
                         k, sa, dir, turn, exp_sa[k], exp_d[k], exp_t[k]);
            else passed++;
        end
    endtask

    task automatic test_load_vs_enable();
        // dir is 1 from down-wrap; load must not disturb it
        mode = 2'b10; lo = 4'd0; hi = 4'd15; en = 1'b1;
        load = 1'b1; load_val = 4'd7;
        tick();
        load = 1'b0;
        total++;
        if ({sa, dir, turn} !== {4'd7, 1'b1, 1'b0})
            $display("FAIL load_edge: got sa=%0d dir=%0b turn=%0b want 7/1/0", sa, dir, turn);
        else passed++;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd6, 1'b1, 1'b0})
            $display("FAIL load_resume1: got sa=%0d dir=%0b turn=%0b want 6/1/0", sa, dir, turn);
        else passed++;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd5, 1'b1, 1'b0})
            $display("FAIL load_resume2: got sa=%0d dir=%0b turn=%0b want 5/1/0", sa, dir, turn);
        else passed++;
    endtask

    task automatic test_hold_and_disable();
        mode = 2'b11;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd5, 1'b1, 1'b0})
            $display("FAIL hold_mode: got sa=%0d dir=%0b turn=%0b want 5/1/0", sa, dir, turn);
        else passed++;
        mode = 2'b10; en = 1'b0;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd5, 1'b1, 1'b0})
            $display("FAIL en_low_hold: got sa=%0d dir=%0b turn=%0b want 5/1/0", sa, dir, turn);
        else passed++;
        en = 1'b1;
    endtask

    task automatic test_invalid_bounds();
        lo = 4'd9; hi = 4'd4;
        #1;
        total++;
        if (err !== 1'b1)
            $display("FAIL err_flag: got err=%0b want 1", err);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({sa, dir, turn} !== {4'd5, 1'b1, 1'b0})
                $display("FAIL err_hold%0d: got sa=%0d dir=%0b turn=%0b want 5/1/0", k, sa, dir, turn);
            else passed++;
        end
        lo = 4'd0;
        #1;
        total++;
        if (err !== 1'b0)
            $display("FAIL err_clear: got err=%0b want 0", err);
        else passed++;
        // sa=5 lies above hi=4, so bounce re-enters at lo going up
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd0, 1'b0, 1'b0})
            $display("FAIL err_recover_clamp: got sa=%0d dir=%0b turn=%0b want 0/0/0", sa, dir, turn);
        else passed++;
        tick();
        total++;
        if ({sa, dir, turn} !== {4'd1, 1'b0, 1'b0})
            $display("FAIL err_recover_count: got sa=%0d dir=%0b turn=%0b want 1/0/0", sa, dir, turn);
        else passed++;
        lo = 4'd5; hi = 4'd5;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({sa, dir, turn} !== {4'd5, 1'b0, 1'b0})
                $display("FAIL lo_eq_hi%0d: got sa=%0d dir=%0b turn=%0b want 5/0/0", k, sa, dir, turn);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_upwrap();
        test_reset_midturn();
        test_downwrap();
        test_load_vs_enable();
        test_hold_and_disable();
        test_invalid_bounds();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
